// File: rtl/oisc8_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oisc8_ram_arbiter
// Purpose  : Shares the oisc8 processor RAM port between the stack, data-memory
//            and COM/DMA paths: round-robin with burst lock and starvation override.
// Revision : 1.0 - initial release
// ============================================================================
module oisc8_ram_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_rd_en,
    output logic                 ram_wr_en,
    output logic [DW-1:0]        ram_wr_data,
    input  logic [DW-1:0]        ram_rd_data,
    output logic                 starved
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_LCK_W = $clog2(MAX_LOCK + 1);
    localparam int c_WT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NREQ - 1);
    localparam logic [c_LCK_W-1:0] c_MAX_LOCK = c_LCK_W'(MAX_LOCK);
    localparam logic [c_WT_W-1:0]  c_MAX_WAIT = c_WT_W'(MAX_WAIT);

    logic [c_IDX_W-1:0] r_last;
    logic               r_hold_lock;
    logic [c_LCK_W-1:0] r_lock_cnt;
    logic [c_WT_W-1:0]  r_wait [NREQ];
    logic [NREQ-1:0]    r_rvalid;
    logic               r_starved;

    logic               w_found;
    logic               w_by_starve;
    logic               w_by_lock;
    logic [c_IDX_W-1:0] w_grantee;
    logic [c_IDX_W-1:0] w_rr;
    logic [NREQ-1:0]    w_gnt;

    // Priority: starvation override, then lock hold, then round-robin after r_last.
    always_comb begin
        w_found     = 1'b0;
        w_by_starve = 1'b0;
        w_by_lock   = 1'b0;
        w_grantee   = r_last;
        w_rr        = '0;
        w_gnt       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (r_wait[i] == c_MAX_WAIT)) begin
                w_found     = 1'b1;
                w_by_starve = 1'b1;
                w_grantee   = c_IDX_W'(i);
            end
        end
        if (!w_found && r_hold_lock && req[r_last] && (r_lock_cnt < c_MAX_LOCK)) begin
            w_found   = 1'b1;
            w_by_lock = 1'b1;
            w_grantee = r_last;
        end
        for (int k = 1; k <= NREQ; k++) begin
            w_rr = c_IDX_W'((int'(r_last) + k) % NREQ);
            if (!w_found && req[w_rr]) begin
                w_found   = 1'b1;
                w_grantee = w_rr;
            end
        end
        if (w_found && rst) begin
            w_gnt[w_grantee] = 1'b1;
        end
    end

    always_comb begin
        ram_addr    = '0;
        ram_wr_data = '0;
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                ram_addr    = addr[i*AW +: AW];
                ram_wr_data = wdata[i*DW +: DW];
                ram_wr_en   = we[i];
                ram_rd_en   = ~we[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last      <= c_LAST_RST;
            r_hold_lock <= 1'b0;
            r_lock_cnt  <= '0;
            r_rvalid    <= '0;
            r_starved   <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_rvalid  <= w_gnt & ~we;
            r_starved <= (|w_gnt) & w_by_starve;
            if (|w_gnt) begin
                r_last      <= w_grantee;
                r_hold_lock <= lock[w_grantee];
                r_lock_cnt  <= w_by_lock ? (r_lock_cnt + c_LCK_W'(1)) : c_LCK_W'(1);
            end else begin
                r_hold_lock <= 1'b0;
                r_lock_cnt  <= '0;
            end
            // A dropped request cancels itself, so its wait history is forgotten.
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || w_gnt[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != c_MAX_WAIT) begin
                    r_wait[i] <= r_wait[i] + c_WT_W'(1);
                end
            end
        end
    end

    assign gnt     = w_gnt;
    assign rvalid  = r_rvalid;
    assign rdata   = ram_rd_data;
    assign starved = r_starved;

endmodule
`default_nettype wire

// File: tb/tb_oisc8_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oisc8_ram_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oisc8_ram_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 24;
    localparam int DW       = 16;
    localparam int MAX_LOCK = 4;
    localparam int MAX_WAIT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    we = '0;
    logic [NREQ-1:0]    lock = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      ram_addr;
    logic               ram_rd_en;
    logic               ram_wr_en;
    logic [DW-1:0]      ram_wr_data;
    logic [DW-1:0]      ram_rd_data = '0;
    logic               starved;

    int checks = 0;
    int errors = 0;

    // Model state: owner of the last grant, length of its current run, and waits.
    int       m_last;
    int       m_run;
    bit       m_hold;
    int       m_wait [NREQ];
    int       m_prev_rd;
    logic [AW-1:0] m_prev_addr;
    bit       m_prev_starve;

    oisc8_ram_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .starved(starved)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
        if (a == 24'h000123) return 16'hBEEF;
        return (a[15:0] * 16'd3) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram_fn(ram_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; we = '0; lock = '0;
        rst = 1'b0;
        #7;
        @(negedge clk);
        rst = 1'b1;
        tick();
        m_last = NREQ - 1; m_run = 0; m_hold = 0;
        m_prev_rd = -1; m_prev_addr = '0; m_prev_starve = 0;
        for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    endtask

    // rule: 1 = starvation, 2 = lock hold, 3 = round-robin, 0 = idle
    task automatic model_grant(output int g, output int rule);
        g = -1; rule = 0;
        for (int i = 0; i < NREQ; i++)
            if (g < 0 && req[i] && m_wait[i] >= MAX_WAIT) begin g = i; rule = 1; end
        if (g < 0 && m_hold && req[m_last] && m_run < MAX_LOCK) begin g = m_last; rule = 2; end
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (g < 0 && req[j]) begin g = j; rule = 3; end
        end
    endtask

    task automatic model_commit(input int g, input int rule);
        for (int i = 0; i < NREQ; i++)
            m_wait[i] = (!req[i] || i == g) ? 0 : ((m_wait[i] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[i] + 1);
        m_prev_starve = (rule == 1);
        m_prev_rd     = (g >= 0 && !we[g]) ? g : -1;
        m_prev_addr   = (g >= 0) ? addr[g*AW +: AW] : '0;
        if (g >= 0) begin
            m_run  = (rule == 2) ? m_run + 1 : 1;
            m_hold = lock[g];
            m_last = g;
        end else begin
            m_run = 0; m_hold = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 3'b111; we = 3'b000;
        #2;
        checks++;
        if ({gnt, rvalid, starved, ram_rd_en, ram_wr_en} !== 9'b0 || ram_addr !== '0 || ram_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b rvalid=%b starved=%b rd=%b wr=%b addr=%h wd=%h expected all zero",
                     gnt, rvalid, starved, ram_rd_en, ram_wr_en, ram_addr, ram_wr_data);
        end
        tick();
        checks++;
        if (rvalid !== 3'b000 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_held rvalid=%b gnt=%b expected 000/000", rvalid, gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant gnt=%b expected 001", gnt);
        end
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        req = 3'b010; we = 3'b000; addr[1*AW +: AW] = 24'h000123;
        #3;
        checks++;
        if (gnt !== 3'b010 || ram_rd_en !== 1'b1 || ram_wr_en !== 1'b0 || ram_addr !== 24'h000123) begin
            errors++;
            $display("FAIL single_read_issue gnt=%b rd=%b wr=%b addr=%h expected 010/1/0/000123",
                     gnt, ram_rd_en, ram_wr_en, ram_addr);
        end
        tick();
        req = 3'b000;
        #3;
        checks++;
        if (rvalid !== 3'b010 || rdata !== 16'hBEEF || gnt !== 3'b000) begin
            errors++;
            $display("FAIL single_read_return rvalid=%b rdata=%h gnt=%b expected 010/BEEF/000", rvalid, rdata, gnt);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 3'b111; we = 3'b111; lock = 3'b000;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = 24'h000100 + 24'(i);
            wdata[i*DW +: DW] = 16'hC000 + 16'(i);
        end
        for (int n = 0; n < 6; n++) begin
            logic [NREQ-1:0] exp_g;
            exp_g = 3'b001 << (n % NREQ);
            #3;
            checks++;
            if (gnt !== exp_g || ram_wr_en !== 1'b1 || ram_rd_en !== 1'b0 || rvalid !== 3'b000
                || ram_wr_data !== 16'hC000 + 16'(n % NREQ)) begin
                errors++;
                $display("FAIL round_robin[%0d] gnt=%b wr=%b rd=%b rvalid=%b wd=%h expected %b/1/0/000/%h",
                         n, gnt, ram_wr_en, ram_rd_en, rvalid, ram_wr_data, exp_g, 16'hC000 + 16'(n % NREQ));
            end
            tick();
        end
    endtask

    task automatic test_lock_limit();
        int exp_seq [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        do_reset();
        req = 3'b011; we = 3'b011; lock = 3'b001;
        for (int n = 0; n < 9; n++) begin
            #3;
            checks++;
            if (gnt !== (3'b001 << exp_seq[n])) begin
                errors++;
                $display("FAIL lock_limit[%0d] gnt=%b expected %b", n, gnt, 3'b001 << exp_seq[n]);
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        do_reset();
        req = 3'b111; we = 3'b111; lock = 3'b011;
        for (int n = 0; n < 10; n++) begin
            #3;
            if (n < 9) begin
                checks++;
                if (gnt !== (3'b001 << exp_seq[n]) || starved !== 1'b0) begin
                    errors++;
                    $display("FAIL starvation[%0d] gnt=%b starved=%b expected %b/0",
                             n, gnt, starved, 3'b001 << exp_seq[n]);
                end
            end else begin
                checks++;
                if (starved !== 1'b1) begin
                    errors++;
                    $display("FAIL starvation_flag starved=%b expected 1", starved);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a_tab [3] = '{24'h000010, 24'h000020, 24'h000030};
        do_reset();
        we = 3'b000;
        for (int n = 0; n < 4; n++) begin
            if (n < 3) begin
                req = 3'b001 << n;
                addr[n*AW +: AW] = a_tab[n];
            end else begin
                req = 3'b000;
            end
            #3;
            if (n < 3) begin
                checks++;
                if (gnt !== (3'b001 << n) || ram_addr !== a_tab[n] || ram_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL pipe_issue[%0d] gnt=%b addr=%h rd=%b expected %b/%h/1",
                             n, gnt, ram_addr, ram_rd_en, 3'b001 << n, a_tab[n]);
                end
            end
            if (n > 0) begin
                checks++;
                if (rvalid !== (3'b001 << (n - 1)) || rdata !== ram_fn(a_tab[n-1])) begin
                    errors++;
                    $display("FAIL pipe_return[%0d] rvalid=%b rdata=%h expected %b/%h",
                             n, rvalid, rdata, 3'b001 << (n - 1), ram_fn(a_tab[n-1]));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b100; we = 3'b000; addr[2*AW +: AW] = 24'h000030;
        #3;
        checks++;
        if (gnt !== 3'b100) begin
            errors++;
            $display("FAIL async_setup gnt=%b expected 100", gnt);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 3'b000 || ram_rd_en !== 1'b0 || rvalid !== 3'b000) begin
            errors++;
            $display("FAIL async_reset gnt=%b rd=%b rvalid=%b expected 000/0/000", gnt, ram_rd_en, rvalid);
        end
        req = 3'b111;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL async_release gnt=%b expected 001", gnt);
        end
        tick();
    endtask

    task automatic test_random();
        int g, rule;
        logic [NREQ-1:0] exp_g, exp_rv;
        logic [AW-1:0]   exp_a;
        logic [DW-1:0]   exp_wd;
        logic            exp_rd, exp_wr;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req  = 3'($urandom) | 3'($urandom);
            we   = 3'($urandom);
            lock = 3'($urandom) | 3'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                addr[i*AW +: AW]  = 24'($urandom);
                wdata[i*DW +: DW] = 16'($urandom);
            end
            #3;
            model_grant(g, rule);
            exp_g  = (g >= 0) ? (3'b001 << g) : 3'b000;
            exp_a  = (g >= 0) ? addr[g*AW +: AW] : '0;
            exp_wd = (g >= 0) ? wdata[g*DW +: DW] : '0;
            exp_wr = (g >= 0) ? we[g] : 1'b0;
            exp_rd = (g >= 0) ? ~we[g] : 1'b0;
            exp_rv = (m_prev_rd >= 0) ? (3'b001 << m_prev_rd) : 3'b000;
            checks++;
            if (gnt !== exp_g || ram_addr !== exp_a || ram_wr_data !== exp_wd
                || ram_wr_en !== exp_wr || ram_rd_en !== exp_rd) begin
                errors++;
                $display("FAIL rand_cmd[%0d] req=%b gnt=%b addr=%h wd=%h wr=%b rd=%b expected %b/%h/%h/%b/%b",
                         n, req, gnt, ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, exp_g, exp_a, exp_wd, exp_wr, exp_rd);
            end
            checks++;
            if (rvalid !== exp_rv || starved !== m_prev_starve
                || (m_prev_rd >= 0 && rdata !== ram_fn(m_prev_addr))) begin
                errors++;
                $display("FAIL rand_ret[%0d] rvalid=%b starved=%b rdata=%h expected %b/%b/%h",
                         n, rvalid, starved, rdata, exp_rv, m_prev_starve, ram_fn(m_prev_addr));
            end
            @(posedge clk);
            model_commit(g, rule);
            #1;
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_limit();
        test_starvation();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
